// File: rtl/toy_mem_pkg.sv
// toy_mem_pkg: shared state encoding, access direction codes and default sizes
package toy_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic RORW_READ = 1'b1;
  localparam logic RORW_WRITE = 1'b0;
  localparam int WAIT_STATES_DEF = 1;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/toy_mem_if.sv
// toy_mem_if: CPU-side memory bus; master drives requests, slave answers
interface toy_mem_if #(
  parameter int ADDR_W = toy_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = toy_mem_pkg::DATA_W_DEF
);
  logic mem_en;
  logic rorw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d_wr;
  logic [DATA_W-1:0] d_rd;
  logic mem_rdy;
  logic busy;
  logic [7:0] acc_cnt;
  modport master (output mem_en, rorw, addr, d_wr, input d_rd, mem_rdy, busy, acc_cnt);
  modport slave (input mem_en, rorw, addr, d_wr, output d_rd, mem_rdy, busy, acc_cnt);
endinterface

// File: rtl/toy_ram.sv
// toy_ram: single-port array, synchronous write and registered synchronous read
module toy_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // storage is never cleared, so contents survive reset
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;
  // read register holds until the next read
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
endmodule

// File: rtl/toy_mem.sv
// toy_mem: wait-stated memory controller with request latching and access counter
module toy_mem import toy_mem_pkg::*; #(
  parameter int WAIT_STATES = WAIT_STATES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic reset,
  toy_mem_if.slave bus
);
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic rorw_q, mem_rdy, enter_done, ram_en, ram_we, rw;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic [DATA_W-1:0] d_q, ram_wdata, rdata;
  logic [7:0] acc_cnt;
  // next state; in IDLE the live bus feeds the RAM so zero-wait accesses complete on acceptance
  always_comb begin
    state_nx = state == IDLE ? (bus.mem_en ? (WAIT_STATES == 0 ? DONE : WAIT) : IDLE)
             : state == WAIT ? (cnt == WS_LAST ? DONE : WAIT) : IDLE;
    enter_done = state_nx == DONE;
    rw = state == IDLE ? bus.rorw : rorw_q;
    ram_addr = state == IDLE ? bus.addr : addr_q;
    ram_wdata = state == IDLE ? bus.d_wr : d_q;
    ram_en = enter_done && reset;
    ram_we = rw == RORW_WRITE;
  end
  // state, wait counter, request latches, completion pulse and access count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rorw_q <= RORW_READ;
      addr_q <= '0;
      d_q <= '0;
      mem_rdy <= 1'b0;
      acc_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == WAIT ? cnt + 4'd1 : '0;
      if (state == IDLE && bus.mem_en) begin
        rorw_q <= bus.rorw;
        addr_q <= bus.addr;
        d_q <= bus.d_wr;
      end
      mem_rdy <= state == DONE;
      if (enter_done) acc_cnt <= acc_cnt + 8'd1;
    end
  toy_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .reset(reset), .en(ram_en), .we(ram_we),
    .addr(ram_addr), .wdata(ram_wdata), .rdata(rdata)
  );
  assign bus.d_rd = rdata;
  assign bus.mem_rdy = mem_rdy;
  assign bus.busy = state != IDLE;
  assign bus.acc_cnt = acc_cnt;
endmodule

// File: tb/tb_toy_mem.sv
// tb_toy_mem: directed checks of toy_mem with one and zero wait states
module tb_toy_mem;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  toy_mem_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
  toy_mem_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
  toy_mem #(.WAIT_STATES(1), .ADDR_W(8), .DATA_W(8)) u1 (.clk(clk), .reset(reset), .bus(b1));
  toy_mem #(.WAIT_STATES(0), .ADDR_W(8), .DATA_W(8)) u0 (.clk(clk), .reset(reset), .bus(b0));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s, input logic en, input logic rw, input logic [7:0] a, input logic [7:0] d);
    if (s) begin b1.mem_en = en; b1.rorw = rw; b1.addr = a; b1.d_wr = d; end
    else begin b0.mem_en = en; b0.rorw = rw; b0.addr = a; b0.d_wr = d; end
  endtask

  function automatic logic [7:0] rd(input bit s);
    return s ? b1.d_rd : b0.d_rd;
  endfunction

  function automatic logic [7:0] acc(input bit s);
    return s ? b1.acc_cnt : b0.acc_cnt;
  endfunction

  // one access; checks BUSY/MEM_RDY timing against the wait-state count, returns at the MEM_RDY cycle
  task automatic access(input bit s, input logic rw, input logic [7:0] a, input logic [7:0] d);
    int ws = s ? 1 : 0;
    @(negedge clk) drive(s, 1'b1, rw, a, d);
    @(negedge clk) drive(s, 1'b0, rw, a, d);
    for (int k = 0; k <= ws + 1; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("busy_ws%0d_k%0d", ws, k), s ? b1.busy : b0.busy, k <= ws);
      chk($sformatf("rdy_ws%0d_k%0d", ws, k), s ? b1.mem_rdy : b0.mem_rdy, k == ws + 1);
    end
  endtask

  initial begin
    int bad;
    int pulses;
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_busy%0d", s), s ? b1.busy : b0.busy, 0);
      chk($sformatf("rst_rdy%0d", s), s ? b1.mem_rdy : b0.mem_rdy, 0);
      chk($sformatf("rst_acc%0d", s), acc(s[0]), 0);
      chk($sformatf("rst_drd%0d", s), rd(s[0]), 0);
    end
    reset = 1'b1;

    access(1, 0, 8'h01, 8'hAA);
    chk("ws1_wr_drd", rd(1), 8'h00);
    access(1, 1, 8'h01, 8'h00);
    chk("ws1_rd_drd", rd(1), 8'hAA);
    chk("ws1_acc", acc(1), 2);

    @(negedge clk) drive(0, 1, 0, 8'h04, 8'hFE);
    @(negedge clk) drive(0, 1, 1, 8'h04, 8'h00);
    chk("ws0_busy_done", b0.busy, 1);
    chk("ws0_drd_after_wr", rd(0), 8'h00);
    chk("ws0_acc1", acc(0), 1);
    @(negedge clk);
    chk("ws0_idle_gap", b0.busy, 0);
    chk("ws0_rdy_wr", b0.mem_rdy, 1);
    @(negedge clk) drive(0, 0, 1, 8'h04, 8'h00);
    chk("ws0_b2b_drd", rd(0), 8'hFE);
    chk("ws0_b2b_busy", b0.busy, 1);
    chk("ws0_acc2", acc(0), 2);
    @(negedge clk);
    chk("ws0_rdy_rd", b0.mem_rdy, 1);

    access(1, 0, 8'h10, 8'h55);
    @(negedge clk) drive(1, 1, 0, 8'h10, 8'hFF);
    @(negedge clk) drive(1, 0, 0, 8'h10, 8'hFF);
    chk("abort_in_wait", b1.busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", b1.busy, 0);
    chk("abort_rdy", b1.mem_rdy, 0);
    chk("abort_acc", acc(1), 0);
    chk("abort_drd", rd(1), 0);
    @(negedge clk);
    chk("abort_busy_hold", b1.busy, 0);
    chk("abort_rdy_hold", b1.mem_rdy, 0);
    chk("abort_acc_hold", acc(1), 0);
    reset = 1'b1;
    access(1, 1, 8'h10, 8'h00);
    chk("abort_old_value", rd(1), 8'h55);
    chk("abort_acc_after", acc(1), 1);
    access(0, 1, 8'h04, 8'h00);
    chk("ws0_mem_kept", rd(0), 8'hFE);

    access(1, 0, 8'h02, 8'h11);
    access(1, 0, 8'h08, 8'h22);
    @(negedge clk) drive(1, 1, 0, 8'h02, 8'h33);
    @(negedge clk) drive(1, 1, 0, 8'h08, 8'h44);
    @(negedge clk) drive(1, 0, 1, 8'h08, 8'h99);
    repeat (2) @(negedge clk);
    access(1, 1, 8'h02, 8'h00);
    chk("mid_change_02", rd(1), 8'h33);
    access(1, 1, 8'h08, 8'h00);
    chk("mid_change_08", rd(1), 8'h22);

    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    drive(1, 1, 1, 8'h02, 8'h00);
    bad = 0;
    pulses = 0;
    for (int e = 0; e < 770; e++) begin
      @(negedge clk);
      if (b1.mem_rdy !== (e % 3 == 2)) bad++;
      if (b1.busy !== (e % 3 != 2)) bad++;
      if (b1.mem_rdy === 1'b1) pulses++;
      if (e == 766) chk("acc_before_wrap", acc(1), 8'h00);
    end
    drive(1, 0, 1, 8'h02, 8'h00);
    chk("hold_pattern_bad", bad, 0);
    chk("hold_pulses", pulses, 256);
    chk("acc_wrap", acc(1), 8'h01);
    chk("hold_drd", rd(1), 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/toy_mem.md
TOY_MEM -- requirements
Module: toy_mem

Interface
REQ-001 Parameter WAIT_STATES, default 1, sets the number of idle cycles between request acceptance and completion (legal range 0..15).
REQ-002 Parameter ADDR_W, default 8, is the address width.
REQ-003 Parameter DATA_W, default 8, is the data width.
REQ-004 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  reset, asynchronous and active-low.
REQ-006 MEM_EN  input  1  request strobe from the CPU.
REQ-007 RORW  input  1  access direction: 1 = read, 0 = write.
REQ-008 ADDR  input  ADDR_W  access address.
REQ-009 D_WR  input  DATA_W  write data, fed by the CPU's D_OUT.
REQ-010 D_RD  output  DATA_W  read data, fed to the CPU's D_IN.
REQ-011 MEM_RDY  output  1  one-cycle access-complete pulse.
REQ-012 BUSY  output  1  high while a request is in progress.
REQ-013 ACC_CNT  output  8  count of completed accesses.

Function
REQ-014 Storage SHALL be 2^ADDR_W words of DATA_W bits, single-port.
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-016 In IDLE, MEM_EN=1 at a rising edge SHALL accept the request, latching ADDR, RORW and D_WR.
REQ-017 On acceptance, the FSM SHALL go to WAIT if WAIT_STATES>0, otherwise directly to DONE.
REQ-018 WAIT SHALL last exactly WAIT_STATES cycles and then go to DONE.
REQ-019 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-020 For a request accepted at edge N, MEM_RDY SHALL be high for exactly the cycle following edge N+WAIT_STATES+1.
REQ-021 A write SHALL commit the latched D_WR to the latched address at the edge that enters DONE.
REQ-022 A read SHALL load D_RD from the latched address at the edge that enters DONE.
REQ-023 D_RD SHALL hold its value until the next read completes; writes SHALL NOT change D_RD.
REQ-024 BUSY SHALL be high in WAIT and DONE, and low in IDLE.
REQ-025 MEM_EN, ADDR, RORW and D_WR SHALL be ignored outside IDLE; changing them mid-access SHALL have no effect.
REQ-026 Back-to-back requests SHALL be spaced at least WAIT_STATES+2 cycles apart; a MEM_EN held high SHALL be re-accepted on the first IDLE edge.
REQ-027 A read of an address written by the immediately preceding access SHALL return the new data.
REQ-028 ACC_CNT SHALL increment by 1 on every entry to DONE and wrap from 8'hFF to 8'h00.
REQ-029 Address arithmetic SHALL have no wrap or offset; ADDR is used directly as the index.

Reset
REQ-030 RESET=0 SHALL immediately force: state IDLE, MEM_RDY=0, BUSY=0, D_RD=0, ACC_CNT=0, wait counter=0.
REQ-031 A write pending when RESET asserts SHALL be abandoned and SHALL NOT commit.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 The first request SHALL be accepted at the first rising edge after RESET deasserts on which MEM_EN=1.

Structure
REQ-034 Shared package toy_mem_pkg SHALL hold:
- the state encoding (IDLE, WAIT, DONE);
- RORW_READ=1'b1 and RORW_WRITE=1'b0;
- the default widths.
REQ-035 The storage array SHALL be the single sub-module toy_ram, a synchronous-write, synchronous-read single-port array; the FSM, counters and latches SHALL stay in toy_mem.

Verification
REQ-036 WAIT_STATES=1: write 8'hAA to 8'h01, then read 8'h01 -> MEM_RDY pulses 2 cycles after each acceptance; D_RD=8'hAA; ACC_CNT=2.
REQ-037 WAIT_STATES=0: write 8'hFE to 8'h04, then immediately read 8'h04 -> D_RD=8'hFE one edge after the read is accepted; back-to-back spacing is 2 cycles.
REQ-038 Assert RESET during WAIT of a write of 8'hFF to 8'h10, then read 8'h10 -> the old value is returned; MEM_RDY, BUSY and ACC_CNT were 0 during reset.
REQ-039 Change ADDR from 8'h02 to 8'h08 and D_WR during WAIT of a write -> only 8'h02 is modified.
REQ-040 Perform 257 accesses -> ACC_CNT wraps to 8'h01; MEM_EN held high continuously -> one acceptance every WAIT_STATES+2 cycles.
